uart_alu_ctrl: RTL and testbench

- Sequencing controller between the UART receiver, the ALU and the UART transmitter.
- Collects three received bytes in order: operand A, operand B, opcode. Holds them on registered outputs that drive the combinational ALU.
- Captures the ALU result and launches one transmit of it, then waits for transmit completion before accepting the next command.
- Owns the only path by which host bytes reach the ALU.

---
 rtl/uart_alu_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_ctrl
// Purpose  : Sequencing controller between the UART receiver, the ALU and the
//            UART transmitter. Collects operand A, operand B and opcode bytes,
//            presents them on registered outputs to the combinational ALU,
//            captures the ALU result, launches one transmit of it and waits for
//            transmit completion before accepting the next command.
// Ports    : i_clk, i_reset (async, active-high)
//            i_s_tick              baud oversampling tick (timeout only)
//            i_rx_done_tick/i_rx_data   received byte strobe and data
//            i_alu_result          combinational ALU output
//            i_tx_done_tick        transmitter finished its stop bit
//            o_data_a/o_data_b/o_opcode registered ALU operands
//            o_tx_start/o_tx_data  transmit request and result byte
//            o_busy                high outside WAIT_A
//            o_overrun             sticky, a byte was dropped
//            o_timeout             one-cycle pulse on command abort
// Options  : define UART_ALU_CTRL_TIMEOUT_EN to enable the inter-byte timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_alu_ctrl #(
  parameter int NB_DATA       = 8,
  parameter int NB_OP         = 6,
  parameter int TIMEOUT_TICKS = 16384
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done_tick,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_opcode,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               o_timeout
);

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_TICKS);

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] data_a_q, data_a_d;
  logic [NB_DATA-1:0] data_b_q, data_b_d;
  logic [NB_OP-1:0]   opcode_q, opcode_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               overrun_q, overrun_d;

  // Abort request for the current partial command (only raised in WAIT_B or
  // WAIT_OP, and never in a cycle where a byte arrives: the byte wins).
  logic               timeout_hit;

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    opcode_d  = opcode_q;
    tx_data_d = tx_data_q;
    overrun_d = overrun_q;

    case (state_q)
      ST_WAIT_A: begin
        if (i_rx_done_tick) begin
          data_a_d = i_rx_data;
          state_d  = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done_tick) begin
          data_b_d = i_rx_data;
          state_d  = ST_WAIT_OP;
        end else if (timeout_hit) begin
          state_d = ST_WAIT_A;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done_tick) begin
          opcode_d = i_rx_data[NB_OP-1:0];
          state_d  = ST_EXEC;
        end else if (timeout_hit) begin
          state_d = ST_WAIT_A;
        end
      end
      ST_EXEC: begin
        tx_data_d = i_alu_result;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (i_tx_done_tick) begin
          state_d = ST_WAIT_A;
        end
      end
      default: begin
        state_d = ST_WAIT_A;
      end
    endcase

    // Bytes arriving while a result is in flight are dropped, including one
    // coinciding with the transmit-done pulse.
    if (i_rx_done_tick &&
        (state_q == ST_EXEC || state_q == ST_SEND || state_q == ST_WAIT_TX)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_WAIT_A;
      data_a_q  <= '0;
      data_b_q  <= '0;
      opcode_q  <= '0;
      tx_data_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      opcode_q  <= opcode_d;
      tx_data_q <= tx_data_d;
      overrun_q <= overrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Inter-byte timeout
  // --------------------------------------------------------------------------
`ifdef UART_ALU_CTRL_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic        in_partial;

  assign in_partial  = (state_q == ST_WAIT_B) || (state_q == ST_WAIT_OP);
  assign timeout_hit = in_partial && (cnt_q == TIMEOUT_LIMIT) && !i_rx_done_tick;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_hit;
    if ((i_rx_done_tick && (state_q == ST_WAIT_A || in_partial)) ||
        (state_d == ST_WAIT_A && state_q != ST_WAIT_A)) begin
      // Accepted byte or (re)entry to WAIT_A restarts the inter-byte window.
      cnt_d = '0;
    end else if (in_partial && i_s_tick && (cnt_q != TIMEOUT_LIMIT)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  // Without the timeout a command waits indefinitely; the tick and limit are
  // intentionally left without function.
  logic unused_timeout_inputs;
  assign unused_timeout_inputs = ^{i_s_tick, TIMEOUT_LIMIT};
  assign timeout_hit           = 1'b0;
  assign o_timeout             = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_data_a   = data_a_q;
  assign o_data_b   = data_b_q;
  assign o_opcode   = opcode_q;
  assign o_tx_data  = tx_data_q;
  assign o_overrun  = overrun_q;
  assign o_tx_start = (state_q == ST_SEND);
  assign o_busy     = (state_q != ST_WAIT_A);

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_alu_ctrl
// Purpose  : Self-checking bench for uart_alu_ctrl. A stand-in ALU drives
//            i_alu_result from the DUT operand outputs; expected transmit bytes
//            are queued when a command is sent and popped on o_tx_start.
//            Define UART_ALU_CTRL_TIMEOUT_EN to include the timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_alu_ctrl;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;

  logic               clk;
  logic               rst;
  logic               s_tick;
  logic               rx_done;
  logic [NB_DATA-1:0] rx_data;
  logic [NB_DATA-1:0] alu_res;
  logic               tx_done;
  logic [NB_DATA-1:0] data_a;
  logic [NB_DATA-1:0] data_b;
  logic [NB_OP-1:0]   opcode;
  logic               tx_start;
  logic [NB_DATA-1:0] tx_data;
  logic               busy;
  logic               overrun;
  logic               timeout;

  int n_vec = 0;
  int n_err = 0;
  logic [NB_DATA-1:0] sb[$];

  uart_alu_ctrl #(
    .NB_DATA      (NB_DATA),
    .NB_OP        (NB_OP),
    .TIMEOUT_TICKS(32)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_s_tick      (s_tick),
    .i_rx_done_tick(rx_done),
    .i_rx_data     (rx_data),
    .i_alu_result  (alu_res),
    .i_tx_done_tick(tx_done),
    .o_data_a      (data_a),
    .o_data_b      (data_b),
    .o_opcode      (opcode),
    .o_tx_start    (tx_start),
    .o_tx_data     (tx_data),
    .o_busy        (busy),
    .o_overrun     (overrun),
    .o_timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NB_DATA-1:0] alu_model(input logic [NB_DATA-1:0] a,
                                                    input logic [NB_DATA-1:0] b,
                                                    input logic [NB_OP-1:0]   op);
    case (op)
      6'h20:   alu_model = a + b;
      6'h22:   alu_model = a - b;
      6'h24:   alu_model = a & b;
      6'h25:   alu_model = a | b;
      6'h26:   alu_model = a ^ b;
      6'h27:   alu_model = ~(a | b);
      default: alu_model = a + b;
    endcase
  endfunction

  assign alu_res = alu_model(data_a, data_b, opcode);

  // Drive one rx byte pulse; returns at the negedge after it was sampled.
  task automatic send_byte(input logic [NB_DATA-1:0] b);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  // Full command up to WAIT_TX, checking operands, latency and result.
  task automatic run_cmd(input logic [NB_DATA-1:0] a,
                         input logic [NB_DATA-1:0] b,
                         input logic [NB_DATA-1:0] opb);
    logic [NB_OP-1:0]   op_lo;
    logic [NB_DATA-1:0] exp;
    op_lo = opb[NB_OP-1:0];
    send_byte(a);
    send_byte(b);
    send_byte(opb);
    sb.push_back(alu_model(a, b, op_lo));
    n_vec++;
    if (data_a !== a || data_b !== b || opcode !== op_lo) begin
      n_err++;
      $display("FAIL operands: got a=%h b=%h op=%h, need a=%h b=%h op=%h",
               data_a, data_b, opcode, a, b, op_lo);
    end
    n_vec++;
    if (tx_start !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL exec_cycle: got tx_start=%b busy=%b, need 0 1", tx_start, busy);
    end
    @(negedge clk);
    n_vec++;
    if (tx_start !== 1'b1) begin
      n_err++;
      $display("FAIL tx_start_pulse: got %b, need 1", tx_start);
    end
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: got tx_data=%h, need queued value", tx_data);
    end else begin
      exp = sb.pop_front();
      if (tx_data !== exp) begin
        n_err++;
        $display("FAIL tx_data: got %h, need %h", tx_data, exp);
      end
    end
    @(negedge clk);
    n_vec++;
    if (tx_start !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL wait_tx: got tx_start=%b busy=%b, need 0 1", tx_start, busy);
    end
  endtask

  task automatic finish_tx;
    pulse_tx_done();
    n_vec++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      n_err++;
      $display("FAIL tx_done_idle: got busy=%b tx_start=%b, need 0 0", busy, tx_start);
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_vec++;
    if (data_a !== '0 || data_b !== '0 || opcode !== '0 || tx_data !== '0 ||
        tx_start !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got a=%h b=%h op=%h txd=%h st=%b busy=%b ovr=%b to=%b, need all 0",
               tag, data_a, data_b, opcode, tx_data, tx_start, busy, overrun, timeout);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");
  endtask

  task automatic test_basic;
    run_cmd(8'h05, 8'h03, 8'h20);
    n_vec++;
    if (tx_data !== 8'h08) begin
      n_err++;
      $display("FAIL add_result: got %h, need 08", tx_data);
    end
    finish_tx();
  endtask

  task automatic test_opcode_mask;
    run_cmd(8'h09, 8'h04, 8'hE2);
    n_vec++;
    if (opcode !== 6'h22) begin
      n_err++;
      $display("FAIL opcode_mask: got %h, need 22", opcode);
    end
    finish_tx();
  endtask

  task automatic test_overrun;
    run_cmd(8'h3C, 8'h0F, 8'h24);
    send_byte(8'h11);
    n_vec++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_set: got ovr=%b busy=%b, need 1 1", overrun, busy);
    end
    finish_tx();
    n_vec++;
    if (data_a !== 8'h3C) begin
      n_err++;
      $display("FAIL overrun_data_a: got %h, need 3c", data_a);
    end
    run_cmd(8'hA5, 8'h5A, 8'h26);
    finish_tx();
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_sticky: got %b, need 1", overrun);
    end
  endtask

  // Byte coinciding with tx_done: dropped, and state still returns to WAIT_A.
  task automatic test_back_to_back;
    run_cmd(8'h81, 8'h02, 8'h22);
    rx_done = 1'b1;
    rx_data = 8'h77;
    tx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    tx_done = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || data_a !== 8'h81 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL same_cycle_drop: got busy=%b a=%h ovr=%b, need 0 81 1",
               busy, data_a, overrun);
    end
    run_cmd(8'hF0, 8'h0F, 8'h25);
    finish_tx();
  endtask

  task automatic test_reset_mid;
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid_cmd");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_cmd(8'h01, 8'h02, 8'h00);
    n_vec++;
    if (tx_data !== 8'h03) begin
      n_err++;
      $display("FAIL reset_recovery: got %h, need 03", tx_data);
    end
    finish_tx();
  endtask

  task automatic test_stray_tx_done;
    pulse_tx_done();
    n_vec++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      n_err++;
      $display("FAIL stray_wait_a: got busy=%b tx_start=%b, need 0 0", busy, tx_start);
    end
    send_byte(8'h44);
    pulse_tx_done();
    n_vec++;
    if (busy !== 1'b1 || tx_start !== 1'b0) begin
      n_err++;
      $display("FAIL stray_wait_b: got busy=%b tx_start=%b, need 1 0", busy, tx_start);
    end
    // Remaining two bytes must land as B and opcode of the same command.
    send_byte(8'h33);
    send_byte(8'h24);
    sb.push_back(alu_model(8'h44, 8'h33, 6'h24));
    @(negedge clk);
    n_vec++;
    if (tx_start !== 1'b1 || data_a !== 8'h44 || data_b !== 8'h33 || tx_data !== sb[0]) begin
      n_err++;
      $display("FAIL stray_cmd: got st=%b a=%h b=%h txd=%h, need 1 44 33 %h",
               tx_start, data_a, data_b, tx_data, sb[0]);
    end
    void'(sb.pop_front());
    @(negedge clk);
    finish_tx();
  endtask

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  task automatic test_timeout;
    send_byte(8'h07);
    for (int i = 0; i < 32; i++) begin
      n_vec++;
      if (timeout !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL timeout_early: tick %0d got to=%b busy=%b, need 0 1", i, timeout, busy);
      end
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
      @(negedge clk);
    end
    // Limit is reached on the last tick; the abort registers one cycle later,
    // which has already elapsed by the negedge above.
    n_vec++;
    if (timeout !== 1'b1 || busy !== 1'b0 || data_a !== 8'h07) begin
      n_err++;
      $display("FAIL timeout_pulse: got to=%b busy=%b a=%h, need 1 0 07", timeout, busy, data_a);
    end
    @(negedge clk);
    n_vec++;
    if (timeout !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_width: got %b, need 0", timeout);
    end
    run_cmd(8'h10, 8'h20, 8'h20);
    finish_tx();
  endtask
`endif

  initial begin
    rst     = 1'b1;
    s_tick  = 1'b0;
    rx_done = 1'b0;
    rx_data = '0;
    tx_done = 1'b0;
    test_reset();
    test_basic();
    test_opcode_mask();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_stray_tx_done();
`ifdef UART_ALU_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d entries, need 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
